// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter placing per-core instruction/data requests onto one shared RAM port.
// A grant is held until RAM answers ACCESS, reports ERROR, times out, or the grantee withdraws.
module memory_arbiter_rr #(
   parameter int CPUS    = 2,
   parameter int ADDR_W  = 32,
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CPUS-1:0]          iREN,
   input  logic [CPUS-1:0]          dREN,
   input  logic [CPUS-1:0]          dWEN,
   input  logic [CPUS*ADDR_W-1:0]   iaddr,
   input  logic [CPUS*ADDR_W-1:0]   daddr,
   input  logic [CPUS*WORD_W-1:0]   dstore,
   output logic [CPUS-1:0]          iwait,
   output logic [CPUS-1:0]          dwait,
   output logic [CPUS*WORD_W-1:0]   iload,
   output logic [CPUS*WORD_W-1:0]   dload,
   output logic                     ramREN,
   output logic                     ramWEN,
   output logic [ADDR_W-1:0]        ramaddr,
   output logic [WORD_W-1:0]        ramstore,
   input  logic [WORD_W-1:0]        ramload,
   input  logic [1:0]               ramstate,
   output logic                     memerr
);

   localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]  gnt_core, win_core, cand, ptr_after;
   logic              gnt_data, win_data, win_found;
   logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
   logic              memerr_nxt;
   logic [CPUS-1:0]   req;
   logic              gnt_live, access, abort;
   int                idx;

   assign req   = dWEN | dREN | iREN;
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

   // First requester at or after rr_ptr, wrapping around the core ring.
   always_comb begin
      win_found = 1'b0;
      win_core  = '0;
      idx       = 0;
      cand      = '0;
      for (int i = 0; i < CPUS; i++) begin
         idx  = (int'(rr_ptr) + i) % CPUS;
         cand = PTR_W'(idx);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_core  = cand;
         end
      end
      win_data = dWEN[win_core] | dREN[win_core];
   end

   assign gnt_live  = gnt_data ? (dWEN[gnt_core] | dREN[gnt_core]) : iREN[gnt_core];
   assign access    = (ramstate == RS_ACCESS);
   assign abort     = (ramstate == RS_ERROR) || (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign ptr_after = (gnt_core == PTR_W'(CPUS - 1)) ? '0 : gnt_core + 1'b1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         tmo_cnt  <= '0;
         memerr   <= 1'b0;
         gnt_core <= '0;
         gnt_data <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         tmo_cnt <= tmo_nxt;
         memerr  <= memerr_nxt;
         if (state == IDLE && win_found) begin
            gnt_core <= win_core;
            gnt_data <= win_data;
         end
      end
   end

   // Withdrawal outranks ACCESS, which outranks ERROR/timeout.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      tmo_nxt    = tmo_cnt;
      memerr_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = GRANT;
               tmo_nxt   = '0;
            end
         end
         GRANT: begin
            if (!gnt_live) begin
               state_nxt = IDLE;
            end else if (access) begin
               rr_ptr_nxt = ptr_after;
               state_nxt  = IDLE;
            end else if (abort) begin
               memerr_nxt = 1'b1;
               rr_ptr_nxt = ptr_after;
               state_nxt  = IDLE;
            end else if (tmo_cnt != '1) begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      iwait    = '1;
      dwait    = '1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (state == GRANT) begin
         if (gnt_data) begin
            ramaddr  = daddr[gnt_core*ADDR_W +: ADDR_W];
            ramstore = dstore[gnt_core*WORD_W +: WORD_W];
            ramWEN   = dWEN[gnt_core];
            ramREN   = dREN[gnt_core] & ~dWEN[gnt_core];
            if (gnt_live && access) dwait[gnt_core] = 1'b0;
         end else begin
            ramaddr = iaddr[gnt_core*ADDR_W +: ADDR_W];
            ramREN  = iREN[gnt_core];
            if (gnt_live && access) iwait[gnt_core] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr: transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_memory_arbiter_rr;

   localparam int CPUS    = 2;
   localparam int ADDR_W  = 32;
   localparam int WORD_W  = 32;
   localparam int TIMEOUT = 4;

   logic                   CLK = 1'b0;
   logic                   RST;
   logic [CPUS-1:0]        iREN, dREN, dWEN;
   logic [CPUS*ADDR_W-1:0] iaddr, daddr;
   logic [CPUS*WORD_W-1:0] dstore;
   logic [CPUS-1:0]        iwait, dwait;
   logic [CPUS*WORD_W-1:0] iload, dload;
   logic                   ramREN, ramWEN;
   logic [ADDR_W-1:0]      ramaddr;
   logic [WORD_W-1:0]      ramstore, ramload;
   logic [1:0]             ramstate;
   logic                   memerr;

   memory_arbiter_rr #(.CPUS(CPUS), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
   );

   always #5 CLK = ~CLK;

   int passed = 0;
   int total  = 0;
   bit mon_en = 1'b0;
   int obs[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Transaction model: who holds the RAM, for how long, and who is next in line.
   bit m_busy = 1'b0;
   int m_core = 0;
   bit m_data = 1'b0;
   int m_next = 0;
   int m_age  = 0;
   bit m_err  = 1'b0;

   always @(posedge CLK) begin
      if (RST) begin
         m_busy = 1'b0; m_next = 0; m_age = 0; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         if (!m_busy) begin
            int best, bestd;
            best = -1; bestd = CPUS;
            for (int k = 0; k < CPUS; k++) begin
               int d;
               d = (k - m_next + CPUS) % CPUS;
               if ((iREN[k] || dREN[k] || dWEN[k]) && d < bestd) begin
                  best = k; bestd = d;
               end
            end
            if (best >= 0) begin
               m_busy = 1'b1; m_core = best; m_data = dREN[best] || dWEN[best]; m_age = 0;
            end
         end else begin
            bit live;
            live = m_data ? (dREN[m_core] || dWEN[m_core]) : iREN[m_core];
            if (!live) m_busy = 1'b0;
            else if (ramstate == 2'd2) begin
               m_busy = 1'b0; m_next = (m_core + 1) % CPUS;
            end else if (ramstate == 2'd3 || m_age + 1 == TIMEOUT) begin
               m_busy = 1'b0; m_next = (m_core + 1) % CPUS; m_err = 1'b1;
            end else m_age++;
         end
      end
   end

   logic [CPUS-1:0]   e_iw, e_dw;
   logic              e_ren, e_wen;
   logic [ADDR_W-1:0] e_addr;
   logic [WORD_W-1:0] e_store;

   always @(negedge CLK) begin
      if (mon_en) begin
         e_iw = '1; e_dw = '1; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
         if (!RST && m_busy) begin
            if (m_data) begin
               e_addr  = daddr[m_core*ADDR_W +: ADDR_W];
               e_store = dstore[m_core*WORD_W +: WORD_W];
               if (dWEN[m_core]) e_wen = 1'b1;
               else if (dREN[m_core]) e_ren = 1'b1;
               if ((dWEN[m_core] || dREN[m_core]) && ramstate == 2'd2) e_dw[m_core] = 1'b0;
            end else begin
               e_addr = iaddr[m_core*ADDR_W +: ADDR_W];
               e_ren  = iREN[m_core];
               if (iREN[m_core] && ramstate == 2'd2) e_iw[m_core] = 1'b0;
            end
         end
         chk("mdl_iwait", iwait, e_iw);
         chk("mdl_dwait", dwait, e_dw);
         chk("mdl_ramREN", ramREN, e_ren);
         chk("mdl_ramWEN", ramWEN, e_wen);
         chk("mdl_ramaddr", ramaddr, e_addr);
         chk("mdl_ramstore", ramstore, e_store);
         chk("mdl_memerr", memerr, RST ? 1'b0 : m_err);
         chk("mdl_dload", dload, {ramload, ramload});
         chk("mdl_iload", iload, {ramload, ramload});
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic clr_in();
      iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = 2'd0;
   endtask

   task automatic do_reset();
      clr_in();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      clr_in();
      tick(); tick();
      settle();
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_dwait", dwait, 2'b11);
      chk("rst_ramREN", ramREN, 1'b0);
      chk("rst_ramWEN", ramWEN, 1'b0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_memerr", memerr, 1'b0);
      mon_en = 1'b1;
      tick();
      RST = 1'b0;

      // single read, two BUSY cycles then ACCESS
      do_reset();
      dREN = 2'b01; daddr[31:0] = 32'h40; ramstate = 2'd1; ramload = 32'hDEADBEEF;
      tick(); settle();
      chk("rd_ramREN", ramREN, 1'b1);
      chk("rd_ramaddr", ramaddr, 32'h40);
      chk("rd_dwait_busy", dwait, 2'b11);
      tick();
      tick(); ramstate = 2'd2; settle();
      chk("rd_dwait_acc", dwait, 2'b10);
      chk("rd_dload", dload[31:0], 32'hDEADBEEF);
      tick(); dREN = '0; ramstate = 2'd0; settle();
      chk("rd_dwait_after", dwait, 2'b11);
      chk("rd_ramREN_after", ramREN, 1'b0);

      // contention: both cores reading, RAM always ACCESS
      do_reset();
      dREN = 2'b11; daddr = {32'h200, 32'h100}; ramstate = 2'd2;
      obs.delete();
      repeat (8) begin
         tick(); settle();
         if (dwait != 2'b11) obs.push_back(dwait[0] ? 1 : 0);
      end
      chk("cont_count", obs.size(), 4);
      if (obs.size() == 4) begin
         chk("cont_g0", obs[0], 0);
         chk("cont_g1", obs[1], 1);
         chk("cont_g2", obs[2], 0);
         chk("cont_g3", obs[3], 1);
      end
      clr_in();

      // intra-core priority: write before instruction fetch
      do_reset();
      iREN = 2'b10; dWEN = 2'b10; daddr[63:32] = 32'h80; dstore[63:32] = 32'h1234;
      iaddr[63:32] = 32'h200; ramstate = 2'd1;
      tick(); settle();
      chk("pri_ramWEN", ramWEN, 1'b1);
      chk("pri_ramREN", ramREN, 1'b0);
      chk("pri_ramaddr", ramaddr, 32'h80);
      chk("pri_ramstore", ramstore, 32'h1234);
      tick(); ramstate = 2'd2; settle();
      chk("pri_dwait", dwait, 2'b01);
      chk("pri_iwait_hold", iwait, 2'b11);
      tick(); dWEN = '0; ramstate = 2'd1; settle();
      chk("pri_bubble", ramWEN | ramREN, 1'b0);
      tick(); ramstate = 2'd2; settle();
      chk("pri_i_ramREN", ramREN, 1'b1);
      chk("pri_i_ramaddr", ramaddr, 32'h200);
      chk("pri_i_ramstore", ramstore, 32'h0);
      chk("pri_iwait", iwait, 2'b01);
      clr_in();

      // timeout after TIMEOUT grant cycles, then the other core is served
      do_reset();
      dREN = 2'b11; daddr = {32'h44, 32'h10}; ramstate = 2'd1;
      tick(); settle();
      chk("tmo_first", ramaddr, 32'h10);
      tick(); tick();
      tick(); settle();
      chk("tmo_not_yet", memerr, 1'b0);
      tick(); settle();
      chk("tmo_memerr", memerr, 1'b1);
      chk("tmo_dwait", dwait, 2'b11);
      chk("tmo_idle", ramREN, 1'b0);
      tick(); settle();
      chk("tmo_next_core", ramaddr, 32'h44);
      chk("tmo_pulse_end", memerr, 1'b0);
      clr_in();

      // ERROR abort, then drop mid-grant leaves rr_ptr alone
      do_reset();
      dREN = 2'b01; daddr = {32'h20, 32'h10}; ramstate = 2'd1;
      tick(); ramstate = 2'd3; settle();
      chk("err_dwait", dwait, 2'b11);
      tick(); settle();
      chk("err_memerr", memerr, 1'b1);
      dREN = 2'b10; ramstate = 2'd1;
      tick(); settle();
      chk("drop_grant1", ramaddr, 32'h20);
      dREN = 2'b01;
      tick(); settle();
      chk("drop_memerr", memerr, 1'b0);
      chk("drop_idle", ramREN, 1'b0);
      dREN = 2'b11;
      tick(); settle();
      chk("drop_ptr_kept", ramaddr, 32'h20);
      clr_in();

      // asynchronous reset in the middle of a grant
      do_reset();
      dREN = 2'b01; daddr = {32'h20, 32'h10}; ramstate = 2'd2;
      tick();
      tick(); dREN = 2'b10; ramstate = 2'd1;
      tick(); settle();
      chk("ar_pre_ramREN", ramREN, 1'b1);
      chk("ar_pre_addr", ramaddr, 32'h20);
      #2 RST = 1'b1;
      #1;
      chk("ar_ramREN", ramREN, 1'b0);
      chk("ar_ramWEN", ramWEN, 1'b0);
      chk("ar_dwait", dwait, 2'b11);
      chk("ar_iwait", iwait, 2'b11);
      @(posedge CLK); #1;
      RST = 1'b0; dREN = 2'b11;
      tick(); settle();
      chk("ar_ptr_zero", ramaddr, 32'h10);
      clr_in();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
